// File: rtl/matinv_pkg.sv
// Shared types and constants for the 3x3 matrix inverse engine.
// Elements are DW-bit signed integers; results are signed Q(DW-FRAC).FRAC.
package matinv_pkg;

   localparam int DW        = 8;
   localparam int FRAC      = 4;
   localparam int ACC_W     = 27;
   localparam int COF_W     = 17;
   localparam int DIV_STEPS = 20;
   localparam int DVD_W     = 28;

   localparam logic [DW-1:0]        Q_MAX     = {1'b0, {(DW-1){1'b1}}};
   localparam logic [DW-1:0]        Q_MIN     = {1'b1, {(DW-1){1'b0}}};
   localparam logic [DIV_STEPS-1:0] Q_POS_LIM = DIV_STEPS'(2**(DW-1) - 1);
   localparam logic [DIV_STEPS-1:0] Q_NEG_LIM = DIV_STEPS'(2**(DW-1));

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      COF  = 3'd1,
      DET  = 3'd2,
      DIV  = 3'd3,
      DONE = 3'd4
   } state_t;

   // Row-major flat index of element (r,c).
   function automatic int elem_idx(input int r, input int c);
      return 3 * r + c;
   endfunction

   // Signed 2x2 product difference p*q - r*s, widened so it never overflows.
   function automatic logic signed [COF_W-1:0] mdiff(
      input logic signed [DW-1:0] p,
      input logic signed [DW-1:0] q,
      input logic signed [DW-1:0] r,
      input logic signed [DW-1:0] s
   );
      return COF_W'(p) * COF_W'(q) - COF_W'(r) * COF_W'(s);
   endfunction

   // Apply the sign to an unsigned quotient magnitude and clamp to the DW-bit range.
   function automatic logic [DW-1:0] sat_q(
      input logic [DIV_STEPS-1:0] mag,
      input logic                 neg,
      input logic                 ovf
   );
      logic [DW-1:0] res;
      if (neg) begin
         if (ovf || (mag > Q_NEG_LIM)) res = Q_MIN;
         else                          res = DW'(-mag);
      end else begin
         if (ovf || (mag > Q_POS_LIM)) res = Q_MAX;
         else                          res = mag[DW-1:0];
      end
      return res;
   endfunction

endpackage

// File: rtl/matinv_sdiv.sv
// Signed iterative restoring divider with saturating DW-bit output.
// Computes sign(a)^sign(b) * (|a|<<FRAC)/|b|: one load cycle, then DIV_STEPS steps.
// done/quotient are valid in the cycle of the final step (captured on its closing edge).
// Build option MATINV_ROUND_NEAREST_EN: adds |divisor|>>1 to the dividend magnitude,
// turning truncation into round-half-away-from-zero.
module matinv_sdiv
   import matinv_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic signed [COF_W-1:0] dividend,
   input  logic signed [ACC_W-1:0] divisor,
   output logic                    busy,
   output logic                    done,
   output logic [DW-1:0]           quotient
);

   localparam logic [4:0] LAST_STEP = 5'(DIV_STEPS - 1);

   logic [COF_W-1:0]     dvd_abs_s;
   logic [ACC_W-1:0]     dvs_abs_s;
   logic [DVD_W-1:0]     dvd_mag_s;
   logic [ACC_W-1:0]     rem_init_s;
   logic [ACC_W:0]       trial_s;
   logic                 ge_s;
   logic [ACC_W-1:0]     rem_nx_s;
   logic [DIV_STEPS-1:0] q_nx_s;

   logic [ACC_W-1:0]     rem_r;
   logic [DIV_STEPS-1:0] dvd_r;
   logic [ACC_W-1:0]     dvs_r;
   logic [DIV_STEPS-2:0] q_r;
   logic [4:0]           cnt_r;
   logic                 neg_r;
   logic                 ovf_r;
   logic                 busy_r;

   // Operand magnitudes, scaled dividend and the partial remainder it starts from
   always_comb begin
      dvd_abs_s = dividend[COF_W-1] ? COF_W'(-dividend) : COF_W'(dividend);
      dvs_abs_s = divisor[ACC_W-1]  ? ACC_W'(-divisor)  : ACC_W'(divisor);
      dvd_mag_s = DVD_W'(dvd_abs_s) << FRAC;
`ifdef MATINV_ROUND_NEAREST_EN
      dvd_mag_s = dvd_mag_s + DVD_W'(dvs_abs_s >> 1);
`endif
      // Bits above the quotient window go straight into the remainder.
      rem_init_s = ACC_W'(dvd_mag_s[DVD_W-1:DIV_STEPS]);
   end

   // One restoring step: shift in the next dividend bit and subtract if it fits
   always_comb begin
      trial_s = {rem_r, dvd_r[DIV_STEPS-1]};
      ge_s    = (trial_s >= {1'b0, dvs_r});
      if (ge_s) rem_nx_s = trial_s[ACC_W-1:0] - dvs_r;
      else      rem_nx_s = trial_s[ACC_W-1:0];
      q_nx_s = {q_r, ge_s};
   end

   // Divider state: load on start, then one restoring step per cycle until the count runs out
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rem_r  <= '0;
         dvd_r  <= '0;
         dvs_r  <= '0;
         q_r    <= '0;
         cnt_r  <= '0;
         neg_r  <= 1'b0;
         ovf_r  <= 1'b0;
         busy_r <= 1'b0;
      end else if (start) begin
         rem_r  <= rem_init_s;
         dvd_r  <= dvd_mag_s[DIV_STEPS-1:0];
         dvs_r  <= dvs_abs_s;
         q_r    <= '0;
         cnt_r  <= '0;
         neg_r  <= dividend[COF_W-1] ^ divisor[ACC_W-1];
         // A quotient too wide for the step window can only saturate.
         ovf_r  <= (rem_init_s >= dvs_abs_s);
         busy_r <= 1'b1;
      end else if (busy_r) begin
         rem_r <= rem_nx_s;
         dvd_r <= {dvd_r[DIV_STEPS-2:0], 1'b0};
         q_r   <= q_nx_s[DIV_STEPS-2:0];
         cnt_r <= cnt_r + 5'd1;
         if (cnt_r == LAST_STEP) busy_r <= 1'b0;
      end
   end

   assign busy     = busy_r;
   assign done     = busy_r && (cnt_r == LAST_STEP);
   assign quotient = sat_q(q_nx_s, neg_r, ovf_r);

endmodule

// File: rtl/matrix_inv3x3.sv
// 3x3 matrix inverse engine: A^-1 = adj(A)/det(A), signed DW-bit in, signed Q4.4 out.
// Sequence IDLE -> COF -> DET -> DIV (9 x 21 cycles through one shared divider) -> DONE.
// A singular matrix skips the divisions and returns all zeros.
// Build option MATINV_ROUND_NEAREST_EN (in matinv_sdiv) selects round-to-nearest.
module matrix_inv3x3
   import matinv_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [9*DW-1:0] matrix_in,
   output logic            done,
   output logic [9*DW-1:0] matrix_out
);

   state_t                  state_r;
   state_t                  state_nx_s;
   logic signed [DW-1:0]    a_r   [0:8];
   logic signed [COF_W-1:0] cof_s [0:8];
   logic signed [COF_W-1:0] adj_r [0:8];
   logic signed [ACC_W-1:0] det_s;
   logic signed [ACC_W-1:0] det_r;
   logic [DW-1:0]           res_r [0:7];
   logic [3:0]              k_r;
   logic                    det_zero_s;
   logic                    div_start_s;
   logic                    load_out_s;
   logic                    div_busy_s;
   logic                    div_done_s;
   logic [DW-1:0]           div_q_s;
   logic [9*DW-1:0]         out_nx_s;
   logic                    done_r;
   logic [9*DW-1:0]         matrix_out_r;

   assign det_zero_s = (det_r == '0);

   // Signed cofactors C(r,c) of the latched matrix
   always_comb begin
      cof_s[0] = mdiff(a_r[4], a_r[8], a_r[5], a_r[7]); // a11 a22 - a12 a21
      cof_s[1] = mdiff(a_r[5], a_r[6], a_r[3], a_r[8]); // a12 a20 - a10 a22
      cof_s[2] = mdiff(a_r[3], a_r[7], a_r[4], a_r[6]); // a10 a21 - a11 a20
      cof_s[3] = mdiff(a_r[2], a_r[7], a_r[1], a_r[8]); // a02 a21 - a01 a22
      cof_s[4] = mdiff(a_r[0], a_r[8], a_r[2], a_r[6]); // a00 a22 - a02 a20
      cof_s[5] = mdiff(a_r[1], a_r[6], a_r[0], a_r[7]); // a01 a20 - a00 a21
      cof_s[6] = mdiff(a_r[1], a_r[5], a_r[2], a_r[4]); // a01 a12 - a02 a11
      cof_s[7] = mdiff(a_r[2], a_r[3], a_r[0], a_r[5]); // a02 a10 - a00 a12
      cof_s[8] = mdiff(a_r[0], a_r[4], a_r[1], a_r[3]); // a00 a11 - a01 a10
   end

   // Determinant by expansion along row 0; C(0,c) sits in column 0 of adj
   always_comb begin
      det_s = ACC_W'(a_r[0]) * ACC_W'(adj_r[elem_idx(0, 0)])
            + ACC_W'(a_r[1]) * ACC_W'(adj_r[elem_idx(1, 0)])
            + ACC_W'(a_r[2]) * ACC_W'(adj_r[elem_idx(2, 0)]);
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_r <= IDLE;
      else      state_r <= state_nx_s;
   end

   // FSM next-state logic
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) state_nx_s = COF;
            else       state_nx_s = IDLE;
         end
         COF: state_nx_s = DET;
         DET: state_nx_s = DIV;
         DIV: begin
            if (det_zero_s)                       state_nx_s = DONE;
            else if (div_done_s && k_r == 4'd8)   state_nx_s = DONE;
            else                                  state_nx_s = DIV;
         end
         DONE: begin
            if (!start) state_nx_s = IDLE;
            else        state_nx_s = DONE;
         end
         default: state_nx_s = IDLE;
      endcase
   end

   // FSM outputs: divider launch and result load strobes
   always_comb begin
      div_start_s = 1'b0;
      load_out_s  = 1'b0;
      case (state_r)
         DIV: begin
            div_start_s = !det_zero_s && !div_busy_s;
            load_out_s  = (state_nx_s == DONE);
         end
         default: begin
            div_start_s = 1'b0;
            load_out_s  = 1'b0;
         end
      endcase
   end

   // Operand latch, transposed cofactors (adjugate) and determinant registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 9; i++) begin
            a_r[i]   <= '0;
            adj_r[i] <= '0;
         end
         det_r <= '0;
      end else begin
         if (state_r == IDLE && start) begin
            for (int i = 0; i < 9; i++) a_r[i] <= matrix_in[i*DW +: DW];
         end
         if (state_r == COF) begin
            for (int r = 0; r < 3; r++)
               for (int c = 0; c < 3; c++)
                  adj_r[elem_idx(r, c)] <= cof_s[elem_idx(c, r)];
         end
         if (state_r == DET) det_r <= det_s;
      end
   end

   // Element counter and per-element quotient capture during DIV
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         k_r <= '0;
         for (int i = 0; i < 8; i++) res_r[i] <= '0;
      end else if (state_r != DIV) begin
         k_r <= '0;
      end else if (div_done_s) begin
         if (k_r < 4'd8) res_r[k_r[2:0]] <= div_q_s;
         k_r <= k_r + 4'd1;
      end
   end

   // Packed result; the last element comes straight from the divider
   always_comb begin
      out_nx_s = '0;
      if (det_zero_s) begin
         out_nx_s = '0;
      end else begin
         for (int i = 0; i < 8; i++) out_nx_s[i*DW +: DW] = res_r[i];
         out_nx_s[8*DW +: DW] = div_q_s;
      end
   end

   // Registered outputs: done tracks the DONE state, result loads on entry to DONE
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         done_r       <= 1'b0;
         matrix_out_r <= '0;
      end else begin
         done_r <= (state_nx_s == DONE);
         if (load_out_s) matrix_out_r <= out_nx_s;
      end
   end

   matinv_sdiv u_sdiv (
      .clk      (clk),
      .rst      (rst),
      .start    (div_start_s),
      .dividend (adj_r[k_r]),
      .divisor  (det_r),
      .busy     (div_busy_s),
      .done     (div_done_s),
      .quotient (div_q_s)
   );

   assign done       = done_r;
   assign matrix_out = matrix_out_r;

endmodule

// File: tb/tb_matrix_inv3x3.sv
// Self-checking bench for matrix_inv3x3: fixed vectors plus a few random matrices,
// expected results queued at stimulus time and compared when done rises.
module tb_matrix_inv3x3;

   logic        clk;
   logic        rst;
   logic        start;
   logic [71:0] matrix_in;
   logic        done;
   logic [71:0] matrix_out;

   int          n_checks;
   int          n_pass;
   logic [71:0] exp_q [$];
   logic [71:0] last_out;

   matrix_inv3x3 dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .matrix_in  (matrix_in),
      .done       (done),
      .matrix_out (matrix_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic logic [71:0] pk9(input logic [7:0] e0, input logic [7:0] e1,
                                       input logic [7:0] e2, input logic [7:0] e3,
                                       input logic [7:0] e4, input logic [7:0] e5,
                                       input logic [7:0] e6, input logic [7:0] e7,
                                       input logic [7:0] e8);
      return {e8, e7, e6, e5, e4, e3, e2, e1, e0};
   endfunction

   // Reference: cyclic-index cofactors, integer division, sign, clamp.
   function automatic logic [71:0] model_inv(input logic [71:0] m, output int det);
      int a [3][3];
      int cf [3][3];
      int num, ad, mag, q, v;
      logic [71:0] res;
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++)
            a[r][c] = int'($signed(m[(3*r+c)*8 +: 8]));
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++)
            cf[r][c] = a[(r+1)%3][(c+1)%3] * a[(r+2)%3][(c+2)%3]
                     - a[(r+1)%3][(c+2)%3] * a[(r+2)%3][(c+1)%3];
      det = a[0][0]*cf[0][0] + a[0][1]*cf[0][1] + a[0][2]*cf[0][2];
      res = '0;
      if (det != 0) begin
         ad = (det < 0) ? -det : det;
         for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
               num = cf[c][r];
               mag = ((num < 0) ? -num : num) * 16;
`ifdef MATINV_ROUND_NEAREST_EN
               mag = mag + ad / 2;
`endif
               q = mag / ad;
               v = ((num < 0) != (det < 0)) ? -q : q;
               if (v > 127)  v = 127;
               if (v < -128) v = -128;
               res[(3*r+c)*8 +: 8] = 8'(v);
            end
      end
      return res;
   endfunction

   task automatic run_case(input string tag, input logic [71:0] m,
                           input logic [71:0] exp_const, input bit use_const);
      logic [71:0] e;
      logic [71:0] popped;
      int          d;
      int          lat;
      int          lat_exp;
      e = model_inv(m, d);
      if (use_const) e = exp_const;
      lat_exp = (d == 0) ? 3 : 191;
      exp_q.push_back(e);
      @(negedge clk);
      matrix_in = m;
      start     = 1'b1;
      @(posedge clk);
      #1;
      matrix_in = ~m;  // must be ignored once latched
      lat = 0;
      for (int n = 1; n <= 400; n++) begin
         @(posedge clk);
         #1;
         if (n == 100 && lat_exp == 191) check_eq({tag, "_hold"}, matrix_out, last_out);
         if (done) begin
            lat = n;
            break;
         end
      end
      check_eq({tag, "_lat"}, 72'(lat), 72'(lat_exp));
      popped = exp_q.pop_front();
      check_eq(tag, matrix_out, popped);
      last_out = e;
      repeat (3) @(posedge clk);
      #1;
      check_eq({tag, "_held"}, 72'(done), 72'(1));
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      #1;
      check_eq({tag, "_drop"}, 72'(done), 72'(0));
   endtask

   logic [71:0] rm;
   logic [7:0]  d6_exp;

   initial begin
      n_checks  = 0;
      n_pass    = 0;
      last_out  = '0;
      rst       = 1'b0;
      start     = 1'b0;
      matrix_in = '0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_done", 72'(done), 72'(0));
      check_eq("rst_out", matrix_out, 72'(0));
      @(negedge clk);
      rst = 1'b1;

      run_case("basic", pk9(8'h01, 8'h02, 8'h03, 8'h02, 8'h01, 8'h05, 8'h03, 8'h05, 8'h06),
               pk9(8'hDA, 8'h06, 8'h0E, 8'h06, 8'hFA, 8'h02, 8'h0E, 8'h02, 8'hFA), 1'b1);
      run_case("ident", pk9(8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01),
               pk9(8'h10, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h10), 1'b1);
      run_case("sing", pk9(8'h01, 8'h02, 8'h03, 8'h02, 8'h04, 8'h06, 8'h01, 8'h01, 8'h01),
               72'(0), 1'b1);
      run_case("neg_diag", pk9(8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'hFF),
               pk9(8'h10, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'hF0), 1'b1);
      run_case("upper", pk9(8'h01, 8'h01, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h01),
               pk9(8'h10, 8'hF0, 8'h10, 8'h00, 8'h10, 8'hF0, 8'h00, 8'h00, 8'h10), 1'b1);
      run_case("sixteenth", pk9(8'h01, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h01),
               pk9(8'h10, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h10), 1'b1);
      run_case("sat", pk9(8'h0A, 8'h09, 8'h00, 8'h09, 8'h08, 8'h00, 8'h00, 8'h00, 8'h01),
               pk9(8'h80, 8'h7F, 8'h00, 8'h7F, 8'h80, 8'h00, 8'h00, 8'h00, 8'h10), 1'b1);
      run_case("third", pk9(8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01),
               pk9(8'h05, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h10), 1'b1);
`ifdef MATINV_ROUND_NEAREST_EN
      d6_exp = 8'h03;
`else
      d6_exp = 8'h02;
`endif
      run_case("sixth", pk9(8'h06, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01),
               pk9(d6_exp, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h10), 1'b1);

      // Reset in the middle of DIV clears everything at once.
      @(negedge clk);
      matrix_in = pk9(8'h01, 8'h02, 8'h03, 8'h02, 8'h01, 8'h05, 8'h03, 8'h05, 8'h06);
      start     = 1'b1;
      repeat (50) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check_eq("midrst_done", 72'(done), 72'(0));
      check_eq("midrst_out", matrix_out, 72'(0));
      last_out = '0;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      run_case("after_rst", pk9(8'h01, 8'h02, 8'h03, 8'h02, 8'h01, 8'h05, 8'h03, 8'h05, 8'h06),
               pk9(8'hDA, 8'h06, 8'h0E, 8'h06, 8'hFA, 8'h02, 8'h0E, 8'h02, 8'hFA), 1'b1);

      for (int t = 0; t < 4; t++) begin
         for (int i = 0; i < 9; i++) rm[i*8 +: 8] = 8'(int'($urandom_range(8)) - 4);
         run_case("rand", rm, 72'(0), 1'b0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
